mux_nway_scan: RTL and testbench
================================

MUX_NWAY_SCAN -- requirements
Module: mux_nway_scan

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the bit width of each data channel and of out.
REQ-002 Parameter WAYS, default 8, SHALL set the channel count; legal values are powers of two, 2..16.
REQ-003 Derived constant SELW = log2(WAYS), 3 by default, SHALL set the width of sel_in and sel.
REQ-004 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 in  input  WAYS*WIDTH  SHALL carry the flattened channels; channel k occupies bits [k*WIDTH +: WIDTH], so channel 0 is the LSBs.
REQ-007 sel_in  input  SELW  SHALL be the channel index loaded when load=1.
REQ-008 load  input  1  SHALL request a direct load of sel_in into sel.
REQ-009 mode  input  1  SHALL select the mode: 0 = manual (sel changes only on load), 1 = scan (sel auto-advances).
REQ-010 enable  input  1  SHALL gate scan advance; it is ignored in manual mode.
REQ-011 mask  input  WAYS  SHALL mark the active channels, one bit per channel; 1 = active.
REQ-012 out  output  WIDTH  SHALL be the registered selected data.
REQ-013 sel  output  SELW  SHALL be the current selection register.
REQ-014 valid  output  1  SHALL be the registered flag indicating that out holds data from an active channel.
REQ-015 wrap  output  1  SHALL be a one-cycle pulse when a scan advance wraps past index WAYS-1.

Function
REQ-016 On every non-reset edge, out SHALL take in[sel] if mask[sel]=1, else 0, and valid SHALL take mask[sel]; both use the pre-edge value of sel, giving 1-cycle latency from sel to out.
REQ-017 Update priority for sel SHALL be: reset > load > scan advance > hold.
REQ-018 load=1 SHALL set sel to sel_in on that edge in either mode; no scan advance occurs on that edge and wrap SHALL be 0.
REQ-019 With mode=1, enable=1 and load=0, sel SHALL advance to the lowest index j > sel with mask[j]=1; if no such j exists, sel SHALL advance to the lowest index j <= sel with mask[j]=1.
REQ-020 wrap SHALL be 1 on exactly those edges where the advance in REQ-019 takes the second branch (search restarted from index 0), and 0 on all other edges.
REQ-021 If exactly one mask bit is set and it equals sel, a scan advance SHALL leave sel unchanged and assert wrap.
REQ-022 If mask is all zeros during scan, sel SHALL hold, wrap SHALL be 0, and valid and out SHALL go 0 on the next edge.
REQ-023 With mode=0, or enable=0, and load=0, sel SHALL hold its value; out and valid SHALL still resample per REQ-016 every edge.
REQ-024 Changes to mask or mode SHALL take effect on the next edge; no state other than sel, out, valid and wrap SHALL exist.
REQ-025 The search in REQ-019 SHALL be combinational and complete within one cycle for every legal WAYS; no multi-cycle search is permitted.

Reset
REQ-026 reset=1 on an edge SHALL force sel=0, out=0, valid=0 and wrap=0, overriding load, mode and enable.
REQ-027 Reset asserted mid-scan SHALL abandon the scan; the first edge after reset deasserts SHALL sample channel 0, with no wrap pulse.

Verification
REQ-028 The bench SHALL cover these directed scenarios (defaults WIDTH=16, WAYS=8; channels 0..7 = 1234, 2345, 3456, 4567, 5678, 6789, 789A, 89AB hex):
- Reset held 2 cycles, then mode=1, enable=1, mask=FF -> out sequence 1234, 2345, ..., 89AB, 1234; wrap=1 only on the edge where sel goes 7->0; valid=1 throughout.
- mode=0, load=1, sel_in=5, then load=0 for 3 cycles -> sel=5; out=6789 from the second edge onward; wrap=0 throughout.
- mode=1, mask=0x24, starting at sel=0 -> sel sequence 2, 5, 2, 5; wrap=1 on each 5->2 step; out alternates 3456 / 6789.
- mask=0x10 with sel=4 in scan -> sel stays 4 and wrap=1 every cycle; mask then set to 0 -> sel holds at 4, valid=0, out=0000, wrap=0.
- load=1, sel_in=3 while scanning at sel=6 -> next sel=3, wrap=0; scanning then resumes 4, 5, ...
- reset=1 for one edge at sel=6 during scan -> sel=0, out=0, valid=0; on the next edge out=1234.

Source files
------------

// File: rtl/mux_nway_scan.sv
// N-way registered channel mux with masked round-robin scan.
// Selection comes from a direct load or from a single-cycle search over mask.
module mux_nway_scan #(
  parameter  int WIDTH = 16,
  parameter  int WAYS  = 8,
  localparam int SELW  = $clog2(WAYS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WAYS*WIDTH-1:0] in,
  input  logic [SELW-1:0]       sel_in,
  input  logic                  load,
  input  logic                  mode,
  input  logic                  enable,
  input  logic [WAYS-1:0]       mask,
  output logic [WIDTH-1:0]      out,
  output logic [SELW-1:0]       sel,
  output logic                  valid,
  output logic                  wrap
);

  logic [WIDTH-1:0] ch [WAYS];
  logic             hi_found;
  logic             lo_found;
  logic [SELW-1:0]  hi_idx;
  logic [SELW-1:0]  lo_idx;
  logic             adv;

  always_comb begin
    for (int k = 0; k < WAYS; k++) begin
      ch[k] = in[k*WIDTH +: WIDTH];
    end
  end

  // Descending walk: the last hit written is the lowest qualifying index.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = WAYS - 1; k >= 0; k--) begin
      if (mask[k]) begin
        if (k > int'(sel)) begin
          hi_found = 1'b1;
          hi_idx   = SELW'(k);
        end else begin
          lo_found = 1'b1;
          lo_idx   = SELW'(k);
        end
      end
    end
  end

  assign adv = mode && enable;

  always_ff @(posedge clock) begin
    if (reset) begin
      sel   <= '0;
      out   <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      out   <= mask[sel] ? ch[sel] : '0;
      valid <= mask[sel];
      wrap  <= 1'b0;
      if (load) begin
        sel <= sel_in;
      end else if (adv) begin
        if (hi_found) begin
          sel <= hi_idx;
        end else if (lo_found) begin
          sel  <= lo_idx;
          wrap <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_nway_scan.sv
// Directed bench for mux_nway_scan.
// Expected values are hand-computed per step.
module tb_mux_nway_scan;

  logic         clock;
  logic         reset;
  logic [127:0] in;
  logic [2:0]   sel_in;
  logic         load;
  logic         mode;
  logic         enable;
  logic [7:0]   mask;
  logic [15:0]  out;
  logic [2:0]   sel;
  logic         valid;
  logic         wrap;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] dat [8];

  mux_nway_scan dut (
    .clock  (clock),
    .reset  (reset),
    .in     (in),
    .sel_in (sel_in),
    .load   (load),
    .mode   (mode),
    .enable (enable),
    .mask   (mask),
    .out    (out),
    .sel    (sel),
    .valid  (valid),
    .wrap   (wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect4(input string tag, input logic [2:0] es,
                         input logic [15:0] eo, input logic ev,
                         input logic ew);
    chk({tag, ".sel"}, 32'(sel), 32'(es));
    chk({tag, ".out"}, 32'(out), 32'(eo));
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
    chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
  endtask

  initial begin
    dat = '{16'h1234, 16'h2345, 16'h3456, 16'h4567,
            16'h5678, 16'h6789, 16'h789A, 16'h89AB};
    for (int k = 0; k < 8; k++) in[k*16 +: 16] = dat[k];
    reset  = 1'b1;
    sel_in = 3'd0;
    load   = 1'b0;
    mode   = 1'b1;
    enable = 1'b1;
    mask   = 8'hFF;

    step();
    step();
    expect4("reset", 3'd0, 16'h0000, 1'b0, 1'b0);

    // Full scan, all channels active
    reset = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      expect4($sformatf("scan%0d", i), 3'(i % 8),
              dat[(i - 1) % 8], 1'b1, 1'(i == 8));
    end

    // Manual load of channel 5
    mode   = 1'b0;
    load   = 1'b1;
    sel_in = 3'd5;
    step();
    expect4("mload", 3'd5, 16'h2345, 1'b1, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect4($sformatf("mhold%0d", i), 3'd5, 16'h6789, 1'b1, 1'b0);
    end

    // Sparse mask 0x24 starting from 0
    mask   = 8'h24;
    load   = 1'b1;
    sel_in = 3'd0;
    step();
    expect4("m24load", 3'd0, 16'h6789, 1'b1, 1'b0);
    load = 1'b0;
    mode = 1'b1;
    step();
    expect4("m24a", 3'd2, 16'h0000, 1'b0, 1'b0);
    step();
    expect4("m24b", 3'd5, 16'h3456, 1'b1, 1'b0);
    step();
    expect4("m24c", 3'd2, 16'h6789, 1'b1, 1'b1);
    step();
    expect4("m24d", 3'd5, 16'h3456, 1'b1, 1'b0);

    // Single active channel equal to sel, then empty mask
    mask   = 8'h10;
    load   = 1'b1;
    sel_in = 3'd4;
    step();
    expect4("m10load", 3'd4, 16'h0000, 1'b0, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect4($sformatf("m10s%0d", i), 3'd4, 16'h5678, 1'b1, 1'b1);
    end
    mask = 8'h00;
    for (int i = 0; i < 2; i++) begin
      step();
      expect4($sformatf("m00s%0d", i), 3'd4, 16'h0000, 1'b0, 1'b0);
    end

    // Load during scan takes priority over advance
    mask   = 8'hFF;
    load   = 1'b1;
    sel_in = 3'd6;
    step();
    expect4("ld6", 3'd6, 16'h5678, 1'b1, 1'b0);
    sel_in = 3'd3;
    step();
    expect4("ld3", 3'd3, 16'h789A, 1'b1, 1'b0);
    load = 1'b0;
    step();
    expect4("res4", 3'd4, 16'h4567, 1'b1, 1'b0);
    step();
    expect4("res5", 3'd5, 16'h5678, 1'b1, 1'b0);
    step();
    expect4("res6", 3'd6, 16'h6789, 1'b1, 1'b0);

    // Reset mid-scan overrides a pending load
    reset  = 1'b1;
    load   = 1'b1;
    sel_in = 3'd7;
    step();
    expect4("rmid", 3'd0, 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    load  = 1'b0;
    step();
    expect4("rpost", 3'd1, 16'h1234, 1'b1, 1'b0);

    // enable=0 holds sel in scan mode
    enable = 1'b0;
    step();
    expect4("enoff", 3'd1, 16'h2345, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
